// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks.
package arith_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic SEL_UNSIGNED = 1'b0;
  localparam logic SEL_SIGNED   = 1'b1;

endpackage

// File: rtl/seq_div_if.sv
// Start/done handshake and operand/result bundle for seq_div.
interface seq_div_if #(parameter int WIDTH = 6);
  logic                 start;
  logic [2*WIDTH-1:0]   a;
  logic [WIDTH-1:0]     b;
  logic                 sel;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     r;
  logic                 busy;
  logic                 done;
  logic                 ovf;
  logic                 dz;

  modport master (output start, a, b, sel, input q, r, busy, done, ovf, dz);
  modport slave  (input start, a, b, sel, output q, r, busy, done, ovf, dz);
endinterface

// File: rtl/cond_neg.sv
// Combinational conditional two's-complement negate.
module cond_neg #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);
  assign dout = neg ? (~din + WIDTH'(1)) : din;
endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// unsigned or two's complement, one quotient bit per clock.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// PREP  | magnitudes, signs, divide-by-zero and pre-overflow flags, counter load
// CALC  | one restoring step per cycle, WIDTH cycles
// FIX   | apply signs, signed range check, register results
// DONE  | done pulse; back to IDLE
module seq_div
  import arith_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic   clk,
  input  logic   rst,
  seq_div_if.slave bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] HALF = {2'b01, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sel_q, sel_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_flag_q, dz_flag_d;
  logic             povf_q, povf_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic             signed_mode;
  logic [DW-1:0]    a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH:0]   trial;
  logic [DW-1:0]    acc_step;
  logic [CW-1:0]    cnt_dec;
  logic             sovf;

  assign signed_mode = (sel_q == SEL_SIGNED);
  assign cnt_dec     = cnt_q - CW'(1);
  assign q_mag       = acc_q[WIDTH-1:0];

  cond_neg #(.WIDTH(DW))    u_neg_a (.din(a_q), .neg(signed_mode & a_q[DW-1]),    .dout(a_mag));
  cond_neg #(.WIDTH(WIDTH)) u_neg_b (.din(b_q), .neg(signed_mode & b_q[WIDTH-1]), .dout(b_mag));
  cond_neg #(.WIDTH(WIDTH)) u_neg_q (.din(q_mag), .neg(quo_neg_q), .dout(q_fix));
  cond_neg #(.WIDTH(WIDTH)) u_neg_r (.din(acc_q[DW-1:WIDTH]), .neg(rem_neg_q), .dout(r_fix));

  // Upper WIDTH+1 bits of the left-shifted partial remainder minus |b|;
  // the borrow bit decides whether the subtraction is kept.
  assign trial    = acc_q[DW-1:WIDTH-1] - {1'b0, b_q};
  assign acc_step = trial[WIDTH] ? {acc_q[DW-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign sovf = signed_mode & (quo_neg_q ? ({1'b0, q_mag} >  HALF)
                                         : ({1'b0, q_mag} >= HALF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= 1'b0;
      acc_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_flag_q <= 1'b0;
      povf_q    <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      acc_q     <= acc_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dz_flag_q <= dz_flag_d;
      povf_q    <= povf_d;
      q_q       <= q_d;
      r_q       <= r_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = PREP;
      PREP:    state_d = CALC;
      CALC:    if (cnt_dec == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dz_flag_d = dz_flag_q;
    povf_d    = povf_q;
    q_d       = q_q;
    r_d       = r_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.b;
          sel_d = bus.sel;
        end
      end
      PREP: begin
        acc_d     = a_mag;
        b_d       = b_mag;
        quo_neg_d = signed_mode & (a_q[DW-1] ^ b_q[WIDTH-1]);
        rem_neg_d = signed_mode & a_q[DW-1];
        dz_flag_d = (b_q == '0);
        povf_d    = (a_mag[DW-1:WIDTH] >= b_mag);
        cnt_d     = CW'(WIDTH);
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_dec;
      end
      FIX: begin
        // Divide-by-zero outranks overflow; remainder then echoes the dividend LSBs.
        if (dz_flag_q) begin
          q_d   = '1;
          r_d   = a_q[WIDTH-1:0];
          ovf_d = 1'b0;
          dz_d  = 1'b1;
        end else if (povf_q || sovf) begin
          q_d   = '0;
          r_d   = '0;
          ovf_d = 1'b1;
          dz_d  = 1'b0;
        end else begin
          q_d   = q_fix;
          r_d   = r_fix;
          ovf_d = 1'b0;
          dz_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      PREP, CALC, FIX: bus.busy = 1'b1;
      DONE:            bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.q   = q_q;
  assign bus.r   = r_q;
  assign bus.ovf = ovf_q;
  assign bus.dz  = dz_q;
endmodule

// File: tb/tb_seq_div.sv
// Directed and sweep bench for seq_div at WIDTH=6 with a result scoreboard.
module tb_seq_div;
  import arith_pkg::*;

  localparam int W = 6;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ovf;
    logic         dz;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  seq_div_if #(.WIDTH(W)) bus ();

  seq_div #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   ai, bi, qv, rv;
    bit   of;
    if (b == '0) begin
      e.q = '1; e.r = a[W-1:0]; e.ovf = 1'b0; e.dz = 1'b1;
      return e;
    end
    if (s == SEL_UNSIGNED) begin
      ai = a; bi = b;
      qv = ai / bi; rv = ai % bi;
      of = (qv > 63);
    end else begin
      ai = $signed(a); bi = $signed(b);
      qv = ai / bi; rv = ai % bi;
      of = (qv > 31) || (qv < -32);
    end
    if (of) begin
      e.q = '0; e.r = '0; e.ovf = 1'b1; e.dz = 1'b0;
    end else begin
      e.q = qv[W-1:0]; e.r = rv[W-1:0]; e.ovf = 1'b0; e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_q"},   32'(bus.q),   32'(e.q));
    chk({tag, "_r"},   32'(bus.r),   32'(e.r));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
    chk({tag, "_dz"},  32'(bus.dz),  32'(e.dz));
  endtask

  // One operation; start sampled at the edge after the first negedge (edge N).
  // Cycle k after that edge: busy for k=1..8, done at k=9.
  task automatic run_op(input string tag, input logic [2*W-1:0] ai, input logic [W-1:0] bi,
                        input logic si, input bit pulse_mid);
    int k;
    bit busy_ok;
    bit seen;
    @(negedge clk);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    bus.start = 1'b1; bus.a = ai; bus.b = bi; bus.sel = si;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 12'($urandom); bus.b = 6'($urandom); bus.sel = 1'($urandom);
    sb.push_back(model(ai, bi, si));
    k = 1; busy_ok = 1'b1; seen = 1'b0;
    while (!seen && k <= 20) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (!bus.busy) busy_ok = 1'b0;
        bus.start = (pulse_mid && k == 3);
        if (pulse_mid && k == 3) begin
          bus.a = 12'h0FF; bus.b = 6'd3; bus.sel = SEL_UNSIGNED;
        end
        @(negedge clk);
        k++;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 32'(k), 32'(W + 3));
    chk({tag, "_busywin"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    if (seen) compare_result(tag);
    else if (sb.size() > 0) void'(sb.pop_front());
  endtask

  initial begin
    int  k;
    bit  seen;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sel = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_q",    32'(bus.q),    32'd0);
    chk("rst_r",    32'(bus.r),    32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ovf",  32'(bus.ovf),  32'd0);
    chk("rst_dz",   32'(bus.dz),   32'd0);
    rst = 1'b0;

    run_op("u155_5",   12'd155, 6'd5,  SEL_UNSIGNED, 1'b0);
    run_op("s_m17_5",  12'hFEF, 6'd5,  SEL_SIGNED,   1'b0);
    run_op("s_m155_5", 12'hF65, 6'd5,  SEL_SIGNED,   1'b0);
    run_op("s_100_m7", 12'd100, 6'h39, SEL_SIGNED,   1'b0);
    run_op("u_ovf",    12'h800, 6'd1,  SEL_UNSIGNED, 1'b0);
    run_op("s_ovf32",  12'd32,  6'd1,  SEL_SIGNED,   1'b0);
    run_op("s_m32",    12'hFE0, 6'd1,  SEL_SIGNED,   1'b0);
    run_op("s_min_m1", 12'h800, 6'h3F, SEL_SIGNED,   1'b0);
    run_op("u_dz",     12'h0AB, 6'd0,  SEL_UNSIGNED, 1'b0);
    run_op("s_dz",     12'h0AB, 6'd0,  SEL_SIGNED,   1'b0);
    run_op("u_max",    12'hFFF, 6'h3F, SEL_UNSIGNED, 1'b0);

    // Start pulse during CALC must neither disturb nor queue an operation.
    run_op("pulse", 12'd200, 6'd7, SEL_UNSIGNED, 1'b1);
    @(negedge clk);
    chk("pulse_no_queue_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("pulse_no_queue_busy2", 32'(bus.busy), 32'd0);

    // Start held high: accepted only in IDLE, done every W+4 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 12'd155; bus.b = 6'd5; bus.sel = SEL_UNSIGNED;
    repeat (3) sb.push_back(model(12'd155, 6'd5, SEL_UNSIGNED));
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      chk("held_done", 32'(bus.done), 32'((c % (W + 4)) == (W + 3)));
      if (bus.done) compare_result("held");
      if (c == 30) bus.start = 1'b0;
    end
    @(negedge clk);
    chk("held_stop_busy", 32'(bus.busy), 32'd0);
    chk("held_sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();

    // Reset during CALC cycle 3: outputs clear at once, aborted op never completes.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 12'd200; bus.b = 6'd7; bus.sel = SEL_UNSIGNED;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_q",    32'(bus.q),    32'd0);
    chk("abort_r",    32'(bus.r),    32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_ovf",  32'(bus.ovf),  32'd0);
    chk("abort_dz",   32'(bus.dz),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op("after_abort", 12'd200, 6'd7, SEL_UNSIGNED, 1'b0);

    // Products of operands divide back exactly.
    for (int x = 0; x < 64; x++) begin
      for (int y = 1; y < 64; y += 2) begin
        run_op("sweep_u", 12'(x * y), 6'(y), SEL_UNSIGNED, 1'b0);
      end
    end
    for (int x = -32; x < 32; x++) begin
      for (int y = -32; y < 32; y += 3) begin
        run_op("sweep_s", 12'(x * y), 6'(y), SEL_SIGNED, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
